// File: rtl/adc_pkg.sv
// Shared definitions for the ADC conversion responder model: result width,
// voltage-source select codes, mode codes, state encoding and the pure
// source-selection helpers used by the responder.
package adc_pkg;

    localparam int ADC_VALUE_W = 14;

    // vsenctl codes understood in voltage mode; anything above LOC_LEFT is invalid
    localparam logic [2:0] VSEN_GLO_LEFT  = 3'b000;
    localparam logic [2:0] VSEN_GLO_RIGHT = 3'b001;
    localparam logic [2:0] VSEN_LOC_LEFT  = 3'b010;

    localparam logic ADCMODE_TEMP = 1'b0;
    localparam logic ADCMODE_VOLT = 1'b1;

    // State encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_CONVERT = ST_CONVERT,
        S_READY   = ST_READY
    } adc_state_e;

    // True when a voltage-mode select code does not map to any source
    function automatic logic vsen_invalid(input logic [2:0] vsen);
        return (vsen > VSEN_LOC_LEFT);
    endfunction

    // Raw source value for a (mode, vsenctl) pair; invalid selects give zero
    function automatic logic [ADC_VALUE_W-1:0] select_source(
        input logic                   mode,
        input logic [2:0]             vsen,
        input logic [ADC_VALUE_W-1:0] src_gl,
        input logic [ADC_VALUE_W-1:0] src_gr,
        input logic [ADC_VALUE_W-1:0] src_ll,
        input logic [ADC_VALUE_W-1:0] src_temp
    );
        logic [ADC_VALUE_W-1:0] val;
        val = '0;
        if (mode == ADCMODE_TEMP) begin
            val = src_temp;
        end else begin
            case (vsen)
                VSEN_GLO_LEFT:  val = src_gl;
                VSEN_GLO_RIGHT: val = src_gr;
                VSEN_LOC_LEFT:  val = src_ll;
                default:        val = '0;
            endcase
        end
        return val;
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A rise of async_i before clock edge N yields a one-cycle rise_o pulse
// during the cycle after edge N+2. Reusable for any asynchronous strobe.
module sync_rise_detect (
    input  logic clk,
    input  logic rst_n_i,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    // Synchronize the strobe, remember its last value, register the edge
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/adc_responder_model.sv
// Responder end of the adcreqi/adcrdy/adcvalue ADC conversion interface.
// A synchronized request starts a fixed-length conversion; the result is
// taken from the per-source input picked by the mode/select captured at
// start, sampled at completion, and presented with a wide adcrdy pulse.
// Optional build macro ADC_RESP_RAMP_EN adds a per-conversion ramp offset
// to every valid result so repeated conversions produce changing values.
module adc_responder_model
    import adc_pkg::*;
#(
    parameter int CONV_CYCLES = 34,
    parameter int RDY_CYCLES  = 4,
    parameter int OVR_W       = 8
) (
    input  logic                   clk,
    input  logic                   i_reset_n,
    input  logic                   adcen,
    input  logic                   adcmode,
    input  logic [2:0]             vsenctl,
    input  logic                   adcreqi,
    input  logic [ADC_VALUE_W-1:0] i_src_gl,
    input  logic [ADC_VALUE_W-1:0] i_src_gr,
    input  logic [ADC_VALUE_W-1:0] i_src_ll,
    input  logic [ADC_VALUE_W-1:0] i_src_temp,
    output logic                   adcrdy,
    output logic [ADC_VALUE_W-1:0] adcvalue,
    output logic                   o_busy,
    output logic [OVR_W-1:0]       o_overrun,
    output logic                   o_sel_err
);

    // One down-counter serves both timed phases, so size it for the longer one
    localparam int CNT_MAX = (CONV_CYCLES > RDY_CYCLES) ? CONV_CYCLES : RDY_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CONV_LOAD = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] RDY_LOAD  = CNT_W'(RDY_CYCLES - 1);

    adc_state_e             state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic                   mode_q,    mode_d;
    logic [2:0]             vsen_q,    vsen_d;
    logic [ADC_VALUE_W-1:0] value_q,   value_d;
    logic                   rdy_q,     rdy_d;
    logic [OVR_W-1:0]       ovr_q,     ovr_d;
    logic                   sel_err_q, sel_err_d;

    logic                   start;
    logic [ADC_VALUE_W-1:0] src_sel;
    logic [ADC_VALUE_W-1:0] conv_result;

    sync_rise_detect u_req_sync (
        .clk     (clk),
        .rst_n_i (i_reset_n),
        .async_i (adcreqi),
        .rise_o  (start)
    );

    // Source chosen by the shadow registers, read live at completion time
    assign src_sel = select_source(mode_q, vsen_q, i_src_gl, i_src_gr, i_src_ll, i_src_temp);

`ifdef ADC_RESP_RAMP_EN
    logic [ADC_VALUE_W-1:0] ramp_q, ramp_d;

    // Valid results get the ramp offset (mod 2^14); invalid selects stay zero
    always_comb begin
        conv_result = src_sel + ramp_q;
        if (mode_q == ADCMODE_VOLT && vsen_invalid(vsen_q)) begin
            conv_result = '0;
        end
    end
`else
    assign conv_result = src_sel;
`endif

    // State, counter, shadow and output registers
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mode_q    <= ADCMODE_TEMP;
            vsen_q    <= VSEN_GLO_LEFT;
            value_q   <= '0;
            rdy_q     <= 1'b0;
            ovr_q     <= '0;
            sel_err_q <= 1'b0;
`ifdef ADC_RESP_RAMP_EN
            ramp_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            vsen_q    <= vsen_d;
            value_q   <= value_d;
            rdy_q     <= rdy_d;
            ovr_q     <= ovr_d;
            sel_err_q <= sel_err_d;
`ifdef ADC_RESP_RAMP_EN
            ramp_q    <= ramp_d;
`endif
        end
    end

    // Next-state logic: request handling, conversion timing, ready pulse
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        vsen_d    = vsen_q;
        value_d   = value_q;
        rdy_d     = rdy_q;
        ovr_d     = ovr_q;
        sel_err_d = sel_err_q;
`ifdef ADC_RESP_RAMP_EN
        ramp_d    = ramp_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                // A start while disabled is dropped silently (not an overrun)
                if (start && adcen) begin
                    mode_d  = adcmode;
                    vsen_d  = vsenctl;
                    cnt_d   = CONV_LOAD;
                    state_d = S_CONVERT;
                    if (adcmode == ADCMODE_VOLT && vsen_invalid(vsenctl)) begin
                        sel_err_d = 1'b1;
                    end
                end
            end

            S_CONVERT: begin
                // Losing enable aborts with no pulse and adcvalue untouched
                if (!adcen) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    value_d = conv_result;
                    rdy_d   = 1'b1;
                    cnt_d   = RDY_LOAD;
                    state_d = S_READY;
`ifdef ADC_RESP_RAMP_EN
                    ramp_d  = ramp_q + 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_READY: begin
                // The pulse always runs to full width, regardless of adcen
                if (cnt_q == '0) begin
                    rdy_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                rdy_d   = 1'b0;
            end
        endcase

        // Any start seen outside IDLE is an ignored request; count it, saturating
        if (start && (state_q != S_IDLE) && (ovr_q != '1)) begin
            ovr_d = ovr_q + 1'b1;
        end
    end

    assign adcrdy    = rdy_q;
    assign adcvalue  = value_q;
    assign o_busy    = (state_q != S_IDLE);
    assign o_overrun = ovr_q;
    assign o_sel_err = sel_err_q;

endmodule

// File: tb/tb_adc_responder_model.sv
// Self-checking bench for adc_responder_model: reset values, a table of
// directed conversions, mid-conversion select change, abort, overrun
// saturation, randomized conversions against a reference model, reset in
// CONVERT, and the ramp wrap case (ADC_RESP_RAMP_EN aware).
module tb_adc_responder_model;
    import adc_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        adcen;
    logic        adcmode;
    logic [2:0]  vsenctl;
    logic        adcreqi;
    logic [13:0] i_src_gl, i_src_gr, i_src_ll, i_src_temp;
    logic        adcrdy;
    logic [13:0] adcvalue;
    logic        o_busy;
    logic [7:0]  o_overrun;
    logic        o_sel_err;

    always #5 clk = ~clk;

    adc_responder_model dut (
        .clk        (clk),
        .i_reset_n  (i_reset_n),
        .adcen      (adcen),
        .adcmode    (adcmode),
        .vsenctl    (vsenctl),
        .adcreqi    (adcreqi),
        .i_src_gl   (i_src_gl),
        .i_src_gr   (i_src_gr),
        .i_src_ll   (i_src_ll),
        .i_src_temp (i_src_temp),
        .adcrdy     (adcrdy),
        .adcvalue   (adcvalue),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun),
        .o_sel_err  (o_sel_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    int          n_done;       // completed conversions since reset (ramp value)
    bit          model_sel_err;
    int          model_ovr;
    logic [13:0] model_last;
    int          rdy_pulses = 0;
    logic        rdy_prev = 1'b0;

    typedef struct {
        bit          mode;
        logic [2:0]  vsen;
        logic [13:0] gl, gr, ll, temp;
        logic [13:0] exp_raw;
        bit          exp_sel_err;
    } vec_t;
    vec_t tbl[8];

    // Count adcrdy rising edges over the whole run
    always @(negedge clk) begin
        rdy_prev <= adcrdy;
        if (adcrdy && !rdy_prev) rdy_pulses <= rdy_pulses + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ovr_exp();
        return (model_ovr > 255) ? 255 : model_ovr;
    endfunction

    // Result the responder should report: source chosen by mode/select,
    // plus the number of earlier completed conversions when the ramp is built in
    function automatic logic [13:0] ref_result(input bit mode, input logic [2:0] vsen,
                                               input logic [13:0] gl, input logic [13:0] gr,
                                               input logic [13:0] ll, input logic [13:0] temp,
                                               input int done);
        int raw;
        if (mode == 1'b0)      raw = int'(temp);
        else if (vsen == 3'd0) raw = int'(gl);
        else if (vsen == 3'd1) raw = int'(gr);
        else if (vsen == 3'd2) raw = int'(ll);
        else                   return 14'h0000;
`ifdef ADC_RESP_RAMP_EN
        raw = (raw + done) % 16384;
`else
        raw = raw + 0 * done;
`endif
        return raw[13:0];
    endfunction

    // Raise a request and wait until the responder reports busy (bounded)
    task automatic request_and_wait_busy(input string tag, output bit ok);
        int k;
        @(negedge clk);
        adcreqi = 1'b1;
        k = 0;
        while (1) begin
            @(negedge clk);
            k++;
            if (o_busy || k >= 20) break;
        end
        check({tag, " req_to_busy"}, k, 4);
        adcreqi = 1'b0;
        ok = o_busy;
    endtask

    // One full conversion: timing, extra overrun requests, optional mid-CONVERT changes
    task automatic run_conv(input string tag, input int n_extra, input int chg_at,
                            input bit chg_mode, input logic [2:0] chg_vsen,
                            input logic [13:0] c_gl, input logic [13:0] c_gr,
                            input logic [13:0] c_ll, input logic [13:0] c_temp,
                            output logic [13:0] got, output int idx, output bit ok);
        bit st_mode;
        logic [2:0] st_vsen;
        bit b_ok;
        int k, w;
        st_mode = adcmode;
        st_vsen = vsenctl;
        got = 14'h0;
        idx = n_done;
        ok  = 1'b0;
        request_and_wait_busy(tag, b_ok);
        if (!b_ok) return;
        if (st_mode && st_vsen > 3'd2) model_sel_err = 1'b1;
        model_ovr += n_extra;
        k = 0;
        while (!adcrdy && k < 100) begin
            if (k >= 2 && k < 2 + 4 * n_extra) adcreqi = ((k - 2) % 4) < 2;
            else adcreqi = 1'b0;
            if (k == chg_at) begin
                adcmode = chg_mode; vsenctl = chg_vsen;
                i_src_gl = c_gl; i_src_gr = c_gr; i_src_ll = c_ll; i_src_temp = c_temp;
            end
            @(negedge clk);
            k++;
        end
        adcreqi = 1'b0;
        check({tag, " busy_to_rdy"}, k, 34);
        if (!adcrdy) return;
        n_done++;
        got = adcvalue;
        w = 0;
        while (adcrdy && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, " rdy_width"}, w, 4);
        check({tag, " busy_after"}, 32'(o_busy), 0);
        check({tag, " sel_err"}, 32'(o_sel_err), 32'(model_sel_err));
        check({tag, " overrun"}, 32'(o_overrun), ovr_exp());
        $display("conv %s: mode=%0d vsen=%0d value=%h overrun=%0d sel_err=%0d",
                 tag, st_mode, st_vsen, got, o_overrun, o_sel_err);
        ok = 1'b1;
    endtask

    // Conversion whose expected value comes from the reference model
    task automatic conv_ref(input string tag, input int n_extra, input int chg_at,
                            input bit chg_mode, input logic [2:0] chg_vsen,
                            input logic [13:0] c_gl, input logic [13:0] c_gr,
                            input logic [13:0] c_ll, input logic [13:0] c_temp,
                            output logic [13:0] got);
        bit st_mode;
        logic [2:0] st_vsen;
        logic [13:0] exp_v;
        int idx;
        bit ok;
        st_mode = adcmode;
        st_vsen = vsenctl;
        run_conv(tag, n_extra, chg_at, chg_mode, chg_vsen, c_gl, c_gr, c_ll, c_temp, got, idx, ok);
        if (!ok) return;
        exp_v = ref_result(st_mode, st_vsen, i_src_gl, i_src_gr, i_src_ll, i_src_temp, idx);
        check({tag, " value"}, 32'(got), 32'(exp_v));
        model_last = exp_v;
    endtask

    task automatic model_reset();
        n_done = 0;
        model_sel_err = 1'b0;
        model_ovr = 0;
        model_last = 14'h0;
    endtask

    initial begin
        logic [13:0] got, exp_v;
        int idx, p0, k;
        bit ok, saw;

        i_reset_n = 1'b0;
        adcen = 1'b1; adcmode = 1'b1; vsenctl = 3'd0; adcreqi = 1'b0;
        i_src_gl = 14'h0; i_src_gr = 14'h0; i_src_ll = 14'h0; i_src_temp = 14'h0;
        model_reset();

        tbl[0] = '{1'b1, 3'd0, 14'h1234, 14'h0ABC, 14'h2AAA, 14'h0555, 14'h1234, 1'b0};
        tbl[1] = '{1'b1, 3'd1, 14'h1234, 14'h0ABC, 14'h2AAA, 14'h0555, 14'h0ABC, 1'b0};
        tbl[2] = '{1'b1, 3'd0, 14'h1234, 14'h0ABC, 14'h2AAA, 14'h0555, 14'h1234, 1'b0};
        tbl[3] = '{1'b1, 3'd1, 14'h1234, 14'h0ABC, 14'h2AAA, 14'h0555, 14'h0ABC, 1'b0};
        tbl[4] = '{1'b0, 3'd3, 14'h1234, 14'h0ABC, 14'h2AAA, 14'h0555, 14'h0555, 1'b0};
        tbl[5] = '{1'b1, 3'd2, 14'h1234, 14'h0ABC, 14'h2AAA, 14'h0555, 14'h2AAA, 1'b0};
        tbl[6] = '{1'b1, 3'd5, 14'h1234, 14'h0ABC, 14'h2AAA, 14'h0555, 14'h0000, 1'b1};
        tbl[7] = '{1'b1, 3'd0, 14'h3FFF, 14'h0ABC, 14'h2AAA, 14'h0555, 14'h3FFF, 1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst adcrdy", 32'(adcrdy), 0);
        check("rst adcvalue", 32'(adcvalue), 0);
        check("rst busy", 32'(o_busy), 0);
        check("rst overrun", 32'(o_overrun), 0);
        check("rst sel_err", 32'(o_sel_err), 0);
        i_reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            adcmode = tbl[i].mode; vsenctl = tbl[i].vsen;
            i_src_gl = tbl[i].gl; i_src_gr = tbl[i].gr;
            i_src_ll = tbl[i].ll; i_src_temp = tbl[i].temp;
            run_conv($sformatf("tbl%0d", i), 0, -1, 1'b0, 3'd0, 14'h0, 14'h0, 14'h0, 14'h0,
                     got, idx, ok);
            if (ok) begin
                exp_v = tbl[i].exp_raw;
`ifdef ADC_RESP_RAMP_EN
                if (exp_v != 14'h0000 || tbl[i].mode == 1'b0 || tbl[i].vsen <= 3'd2)
                    exp_v = 14'(int'(exp_v) + idx);
`endif
                check($sformatf("tbl%0d value", i), 32'(got), 32'(exp_v));
                check($sformatf("tbl%0d sel_err_tbl", i), 32'(o_sel_err), 32'(tbl[i].exp_sel_err));
                model_last = exp_v;
            end
        end

        // Changing vsenctl 10 cycles into CONVERT must not affect the result
        adcmode = 1'b1; vsenctl = 3'd0;
        i_src_gl = 14'h1234; i_src_gr = 14'h0ABC;
        conv_ref("vsen_change", 0, 10, 1'b1, 3'd1, 14'h1234, 14'h0ABC, i_src_ll, i_src_temp, got);

        // Drop adcen at cycle 5 of CONVERT: abort, no pulse, value kept
        adcmode = 1'b1; vsenctl = 3'd1; i_src_gr = 14'h1111;
        p0 = rdy_pulses;
        request_and_wait_busy("abort", ok);
        repeat (5) @(negedge clk);
        adcen = 1'b0;
        @(negedge clk);
        check("abort busy_next", 32'(o_busy), 0);
        saw = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (adcrdy) saw = 1'b1;
        end
        check("abort no_rdy", 32'(saw), 0);
        check("abort pulses", rdy_pulses - p0, 0);
        check("abort value_kept", 32'(adcvalue), 32'(model_last));
        $display("abort: value=%h busy=%0d", adcvalue, o_busy);
        adcen = 1'b1;
        repeat (2) @(negedge clk);

        // Randomized conversions, with extra requests and mid-CONVERT changes
        for (int i = 0; i < 20; i++) begin
            adcmode  = 1'($urandom_range(0, 1));
            vsenctl  = 3'($urandom_range(0, 7));
            i_src_gl = 14'($urandom_range(0, 16383)); i_src_gr   = 14'($urandom_range(0, 16383));
            i_src_ll = 14'($urandom_range(0, 16383)); i_src_temp = 14'($urandom_range(0, 16383));
            conv_ref($sformatf("rnd%0d", i), int'($urandom_range(0, 3)), int'($urandom_range(1, 30)),
                     1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)),
                     14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), got);
        end

        // Flood of ignored requests: overrun saturates, one pulse per conversion
        adcmode = 1'b1; vsenctl = 3'd0; i_src_gl = 14'h0F0F;
        p0 = rdy_pulses;
        for (int i = 0; i < 43; i++) begin
            conv_ref($sformatf("ovr%0d", i), 7, -1, 1'b1, 3'd0,
                     i_src_gl, i_src_gr, i_src_ll, i_src_temp, got);
        end
        @(negedge clk);
        check("ovr saturated", 32'(o_overrun), 32'hFF);
        check("ovr pulses", rdy_pulses - p0, 43);

        // Asynchronous reset in the middle of CONVERT
        request_and_wait_busy("rst_mid", ok);
        repeat (10) @(negedge clk);
        #2 i_reset_n = 1'b0;
        #1;
        check("rst_mid adcrdy", 32'(adcrdy), 0);
        check("rst_mid adcvalue", 32'(adcvalue), 0);
        check("rst_mid busy", 32'(o_busy), 0);
        check("rst_mid overrun", 32'(o_overrun), 0);
        check("rst_mid sel_err", 32'(o_sel_err), 0);
        $display("reset mid-convert: busy=%0d value=%h", o_busy, adcvalue);
        model_reset();
        @(negedge clk);
        i_reset_n = 1'b1;
        k = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_busy || adcrdy) k++;
        end
        check("rst_mid stays_idle", k, 0);

        // Three conversions of loc_left = 3FFF (ramp wrap case when enabled)
        adcmode = 1'b1; vsenctl = 3'd2; i_src_ll = 14'h3FFF;
        for (int i = 0; i < 3; i++) begin
            conv_ref($sformatf("ramp%0d", i), 0, -1, 1'b1, 3'd2,
                     i_src_gl, i_src_gr, i_src_ll, i_src_temp, got);
        end
`ifdef ADC_RESP_RAMP_EN
        check("ramp third", 32'(adcvalue), 32'h0001);
`else
        check("ramp third", 32'(adcvalue), 32'h3FFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adc_responder_model.md
Name: adc_responder_model

Overview:
- Synthesizable stand-in for the GW5A ADC hard IP: the responder end of the adcreqi/adcrdy/adcvalue conversion interface.
- Accepts conversion requests from the existing ADC sequencer and returns 14-bit results after a fixed conversion latency.
- Each result is taken from a per-source input selected by adcmode/vsenctl.
- Used in simulation and on boards without analog stimulus, so the sequencer and channel-switching logic can be exercised deterministically.

Parameters:
- CONV_CYCLES, 34, clk cycles spent in CONVERT (min 1).
- RDY_CYCLES, 4, clk cycles adcrdy stays high (min 1). Consumers clock on posedge adcrdy, so the pulse must be wide.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- adcen  in  1  enable, active high.
- adcmode  in  1  0 = temperature, 1 = voltage.
- vsenctl  in  3  source select in voltage mode: 000 glo_left, 001 glo_right, 010 loc_left.
- adcreqi  in  1  conversion request; may be asynchronous to clk (derived clocks).
- i_src_gl  in  14  value returned for glo_left.
- i_src_gr  in  14  value returned for glo_right.
- i_src_ll  in  14  value returned for loc_left.
- i_src_temp  in  14  value returned in temperature mode.
- adcrdy  out  1  result-valid pulse.
- adcvalue  out  14  last completed result.
- o_busy  out  1  high outside IDLE.
- o_overrun  out  OVR_W  saturating count of ignored requests.
- o_sel_err  out  1  sticky: a voltage-mode conversion was started with vsenctl in 011..111.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, i_reset_n).
- Reset values: adcrdy 0, adcvalue 0, o_busy 0, o_overrun 0, o_sel_err 0, state IDLE, synchronizer flops 0.
- Request detection: adcreqi passes through a 2-flop synchronizer, then a rising-edge detector. If adcreqi rises before clk edge N, the start pulse is high during the cycle after edge N+2.
- States: IDLE, CONVERT, READY.
- IDLE:
  - start && adcen: capture adcmode and vsenctl into shadow registers, load the cycle counter with CONV_CYCLES-1, go to CONVERT, o_busy=1.
  - start && !adcen: ignored, not counted.
- CONVERT:
  - Count down to 0; at the edge leaving count 0, latch the selected source into adcvalue, set adcrdy=1, load the counter with RDY_CYCLES-1, go to READY.
  - The source is sampled at completion, not at start.
- READY: count down; at the edge leaving count 0, adcrdy=0, go to IDLE, o_busy=0.
- Request to done latency: adcrdy rises exactly CONV_CYCLES clk cycles after the IDLE→CONVERT edge.
- Source selection uses the shadow registers, so changing vsenctl or adcmode mid-conversion has no effect:
  - adcmode=0: i_src_temp.
  - adcmode=1, vsenctl 000: i_src_gl.
  - adcmode=1, vsenctl 001: i_src_gr.
  - adcmode=1, vsenctl 010: i_src_ll.
  - adcmode=1, vsenctl 011..111: result 14'h0000; set o_sel_err at start.
- Requests in CONVERT or READY: start pulses are ignored; o_overrun increments by 1 and saturates at all-ones.
- adcen falls during CONVERT: abort to IDLE next edge. No adcrdy pulse, adcvalue unchanged, o_busy=0.
- adcen falls during READY: the pulse completes normally.
- Start in the same cycle READY finishes: ignored and counted. IDLE must be reached first.
- adcvalue holds between conversions.
- Reset mid-operation returns all outputs to their reset values immediately.

Optional Feature:
- Macro: ADC_RESP_RAMP_EN.
- Defined: a 14-bit ramp register (reset 0) increments by 1 on every completed conversion and wraps 3FFF→0000. The result is the selected source plus ramp, modulo 2^14. The invalid-select result stays 0000.
- Undefined: the ramp register is absent; results equal the source exactly.

Decomposition:
- Package adc_pkg:
  - ADC_VALUE_W=14.
  - VSEN_GLO_LEFT=3'b000, VSEN_GLO_RIGHT=3'b001, VSEN_LOC_LEFT=3'b010.
  - ADCMODE_TEMP=0, ADCMODE_VOLT=1.
  - State encoding localparams.
- Sub-module sync_rise_detect: 2-flop synchronizer plus edge detector, reused for other asynchronous strobes.

Test Plan:
- Defaults, adcmode=1, vsenctl=000, i_src_gl=14'h1234, one adcreqi rise → adcrdy high 34 cycles after o_busy rises, lasting 4 cycles; adcvalue=14'h1234; o_overrun=0.
- Alternate vsenctl 000/001 across 4 requests, i_src_gr=14'h0ABC → adcvalue sequence 1234, 0ABC, 1234, 0ABC.
- Change vsenctl from 000 to 001 10 cycles into CONVERT → result is still 14'h1234.
- Issue 300 requests during CONVERT/READY → o_overrun=8'hFF (saturated); no extra adcrdy pulses.
- Drop adcen at cycle 5 of CONVERT → no adcrdy; adcvalue keeps its previous value; o_busy=0 next cycle.
- Request with adcmode=1, vsenctl=101 → adcvalue=0000, o_sel_err=1. Reset mid-CONVERT → all outputs 0. With ADC_RESP_RAMP_EN, the third conversion of i_src_ll=14'h3FFF yields 14'h0001.
